// File: rtl/mem_ctrl_pkg.sv
// Shared op codes, FSM state encoding and stack-pointer constants for the
// memory access controller.
package mem_ctrl_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned SP_SEL_W = 2;

    localparam logic [OP_W-1:0] OP_NOP    = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD   = 3'b001;
    localparam logic [OP_W-1:0] OP_STORE  = 3'b010;
    localparam logic [OP_W-1:0] OP_PUSH   = 3'b011;
    localparam logic [OP_W-1:0] OP_POP    = 3'b100;
    localparam logic [OP_W-1:0] OP_PUSH32 = 3'b101;
    localparam logic [OP_W-1:0] OP_POP32  = 3'b110;
    localparam logic [OP_W-1:0] OP_RSVD   = 3'b111;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [STATE_W-1:0] ST_WORD0 = 2'b01;
    localparam logic [STATE_W-1:0] ST_WORD1 = 2'b10;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'b11;

    localparam logic [15:0] SP_RESET_DEFAULT = 16'hFFFF;

    localparam logic [SP_SEL_W-1:0] SP_INC1 = 2'b00;
    localparam logic [SP_SEL_W-1:0] SP_INC2 = 2'b01;
    localparam logic [SP_SEL_W-1:0] SP_DEC1 = 2'b10;
    localparam logic [SP_SEL_W-1:0] SP_DEC2 = 2'b11;

    // NOP and the reserved code are accepted but never touch memory
    function automatic logic op_is_access(input logic [OP_W-1:0] op);
        return (op != OP_NOP) && (op != OP_RSVD);
    endfunction

    function automatic logic op_is_double(input logic [OP_W-1:0] op);
        return (op == OP_PUSH32) || (op == OP_POP32);
    endfunction

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register with modulo +1/+2/-1/-2 update.
module stack_pointer
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned     WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(SP_RESET_DEFAULT)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_update,
    input  logic [SP_SEL_W-1:0] i_sel,
    output logic [WIDTH-1:0]    o_sp
);

    logic [WIDTH-1:0] r_sp;
    logic [WIDTH-1:0] w_sp_next;

    always_comb begin
        w_sp_next = r_sp;
        case (i_sel)
            SP_INC1: w_sp_next = r_sp + WIDTH'(1);
            SP_INC2: w_sp_next = r_sp + WIDTH'(2);
            SP_DEC1: w_sp_next = r_sp - WIDTH'(1);
            SP_DEC2: w_sp_next = r_sp - WIDTH'(2);
            default: w_sp_next = r_sp;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sp <= RESET_VALUE;
        end else if (i_update) begin
            r_sp <= w_sp_next;
        end
    end

    assign o_sp = r_sp;

endmodule

// File: rtl/memory_access_controller.sv
// Sequences LOAD/STORE and 16/32-bit stack operations onto a single-port
// data memory, one word per cycle, with registered memory strobes.
module memory_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] SP_RESET   = ADDR_WIDTH'(SP_RESET_DEFAULT)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_req_valid,
    input  logic [OP_W-1:0]         i_op,
    input  logic [ADDR_WIDTH-1:0]   i_address,
    input  logic [2*DATA_WIDTH-1:0] i_write_data,
    output logic                    o_ready,
    output logic                    o_done,
    output logic [2*DATA_WIDTH-1:0] o_read_data,
    output logic [ADDR_WIDTH-1:0]   o_sp,
    output logic [ADDR_WIDTH-1:0]   o_mem_address,
    output logic [DATA_WIDTH-1:0]   o_mem_write_data,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    input  logic [DATA_WIDTH-1:0]   i_mem_read_data
);

    logic [STATE_W-1:0]      r_state,      w_state_next;
    logic [OP_W-1:0]         r_op,         w_op_next;
    logic [DATA_WIDTH-1:0]   r_wdata_lo,   w_wdata_lo_next;
    logic [DATA_WIDTH-1:0]   r_read_lo,    w_read_lo_next;
    logic                    r_ready,      w_ready_next;
    logic                    r_done,       w_done_next;
    logic                    r_mem_read,   w_mem_read_next;
    logic                    r_mem_write,  w_mem_write_next;
    logic [ADDR_WIDTH-1:0]   r_mem_addr,   w_mem_addr_next;
    logic [DATA_WIDTH-1:0]   r_mem_wdata,  w_mem_wdata_next;
    logic [2*DATA_WIDTH-1:0] r_read_data,  w_read_data_next;

    logic                    w_sp_update;
    logic [SP_SEL_W-1:0]     w_sp_sel;
    logic [ADDR_WIDTH-1:0]   w_sp;
    logic [ADDR_WIDTH-1:0]   w_sp_p1;
    logic [ADDR_WIDTH-1:0]   w_sp_p2;
    logic [ADDR_WIDTH-1:0]   w_sp_m1;

    assign w_sp_p1 = w_sp + ADDR_WIDTH'(1);
    assign w_sp_p2 = w_sp + ADDR_WIDTH'(2);
    assign w_sp_m1 = w_sp - ADDR_WIDTH'(1);

    stack_pointer #(
        .WIDTH       (ADDR_WIDTH),
        .RESET_VALUE (SP_RESET)
    ) u_stack_pointer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_update (w_sp_update),
        .i_sel    (w_sp_sel),
        .o_sp     (w_sp)
    );

    // Next-state and next-output logic; memory strobes are computed one
    // cycle ahead so they appear registered in WORD0/WORD1.
    always_comb begin
        w_state_next     = r_state;
        w_op_next        = r_op;
        w_wdata_lo_next  = r_wdata_lo;
        w_read_lo_next   = r_read_lo;
        w_ready_next     = 1'b0;
        w_done_next      = 1'b0;
        w_mem_read_next  = 1'b0;
        w_mem_write_next = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_read_data_next = r_read_data;
        w_sp_update      = 1'b0;
        w_sp_sel         = SP_INC1;

        case (r_state)
            ST_IDLE: begin
                w_ready_next = 1'b1;
                if (i_req_valid && r_ready && op_is_access(i_op)) begin
                    w_state_next    = ST_WORD0;
                    w_ready_next    = 1'b0;
                    w_op_next       = i_op;
                    w_wdata_lo_next = i_write_data[DATA_WIDTH-1:0];
                    case (i_op)
                        OP_LOAD: begin
                            w_mem_read_next = 1'b1;
                            w_mem_addr_next = i_address;
                        end
                        OP_STORE: begin
                            w_mem_write_next = 1'b1;
                            w_mem_addr_next  = i_address;
                            w_mem_wdata_next = i_write_data[DATA_WIDTH-1:0];
                        end
                        OP_PUSH: begin
                            w_mem_write_next = 1'b1;
                            w_mem_addr_next  = w_sp;
                            w_mem_wdata_next = i_write_data[DATA_WIDTH-1:0];
                        end
                        OP_PUSH32: begin
                            w_mem_write_next = 1'b1;
                            w_mem_addr_next  = w_sp;
                            w_mem_wdata_next = i_write_data[2*DATA_WIDTH-1:DATA_WIDTH];
                        end
                        default: begin
                            w_mem_read_next = 1'b1;
                            w_mem_addr_next = w_sp_p1;
                        end
                    endcase
                end
            end
            ST_WORD0: begin
                if (op_is_double(r_op)) begin
                    w_state_next = ST_WORD1;
                    if (r_op == OP_PUSH32) begin
                        w_mem_write_next = 1'b1;
                        w_mem_addr_next  = w_sp_m1;
                        w_mem_wdata_next = r_wdata_lo;
                    end else begin
                        w_mem_read_next = 1'b1;
                        w_mem_addr_next = w_sp_p2;
                        w_read_lo_next  = i_mem_read_data;
                    end
                end else begin
                    w_state_next = ST_DONE;
                    w_done_next  = 1'b1;
                    if ((r_op == OP_LOAD) || (r_op == OP_POP)) begin
                        w_read_data_next = {{DATA_WIDTH{1'b0}}, i_mem_read_data};
                    end
                end
            end
            ST_WORD1: begin
                w_state_next = ST_DONE;
                w_done_next  = 1'b1;
                if (r_op == OP_POP32) begin
                    w_read_data_next = {i_mem_read_data, r_read_lo};
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_ready_next = 1'b1;
                // SP moves only as the operation retires, so a reset earlier aborts cleanly
                case (r_op)
                    OP_PUSH:   begin w_sp_update = 1'b1; w_sp_sel = SP_DEC1; end
                    OP_POP:    begin w_sp_update = 1'b1; w_sp_sel = SP_INC1; end
                    OP_PUSH32: begin w_sp_update = 1'b1; w_sp_sel = SP_DEC2; end
                    OP_POP32:  begin w_sp_update = 1'b1; w_sp_sel = SP_INC2; end
                    default:   w_sp_update = 1'b0;
                endcase
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_wdata_lo  <= '0;
            r_read_lo   <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_read_data <= '0;
        end else begin
            r_state     <= w_state_next;
            r_op        <= w_op_next;
            r_wdata_lo  <= w_wdata_lo_next;
            r_read_lo   <= w_read_lo_next;
            r_ready     <= w_ready_next;
            r_done      <= w_done_next;
            r_mem_read  <= w_mem_read_next;
            r_mem_write <= w_mem_write_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_read_data <= w_read_data_next;
        end
    end

    assign o_ready          = r_ready;
    assign o_done           = r_done;
    assign o_read_data      = r_read_data;
    assign o_sp             = w_sp;
    assign o_mem_address    = r_mem_addr;
    assign o_mem_write_data = r_mem_wdata;
    assign o_mem_read       = r_mem_read;
    assign o_mem_write      = r_mem_write;

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench for memory_access_controller with a behavioural
// combinational-read data memory and a strobe log.
module tb_memory_access_controller;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic [2:0]  i_op;
    logic [15:0] i_address;
    logic [31:0] i_write_data;
    logic        o_ready;
    logic        o_done;
    logic [31:0] o_read_data;
    logic [15:0] o_sp;
    logic [15:0] o_mem_address;
    logic [15:0] o_mem_write_data;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [15:0] w_mem_rdata;

    logic [15:0] mem [0:65535];
    logic [31:0] wlog [$];
    logic [15:0] rlog [$];
    int          done_cnt = 0;
    logic        both_seen = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_access_controller dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_req_valid      (i_req_valid),
        .i_op             (i_op),
        .i_address        (i_address),
        .i_write_data     (i_write_data),
        .o_ready          (o_ready),
        .o_done           (o_done),
        .o_read_data      (o_read_data),
        .o_sp             (o_sp),
        .o_mem_address    (o_mem_address),
        .o_mem_write_data (o_mem_write_data),
        .o_mem_read       (o_mem_read),
        .o_mem_write      (o_mem_write),
        .i_mem_read_data  (w_mem_rdata)
    );

    assign w_mem_rdata = mem[o_mem_address];

    // Memory write and strobe log, sampled mid-cycle
    always @(negedge clk) begin
        if (o_mem_write) begin
            mem[o_mem_address] <= o_mem_write_data;
            wlog.push_back({o_mem_address, o_mem_write_data});
        end
        if (o_mem_read) rlog.push_back(o_mem_address);
        if (o_mem_read && o_mem_write) both_seen <= 1'b1;
        if (o_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then drop it
    task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] wd);
        i_req_valid  = 1'b1;
        i_op         = op;
        i_address    = addr;
        i_write_data = wd;
        step();
        i_req_valid  = 1'b0;
        i_op         = 3'b000;
    endtask

    // Cycles from acceptance edge until o_done is seen (bounded)
    task automatic wait_done(output int lat);
        lat = 1;
        while (!o_done && lat < 8) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int wb;
        int rb;
        int db;

        i_reset      = 1'b1;
        i_req_valid  = 1'b0;
        i_op         = 3'b000;
        i_address    = 16'h0000;
        i_write_data = 32'h0;
        step();
        step();
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_sp", 32'(o_sp), 32'h0000_FFFF);
        check("rst_rdata", o_read_data, 32'h0);
        check("rst_strobes", 32'({o_mem_read, o_mem_write}), 32'd0);
        check("rst_maddr", 32'(o_mem_address), 32'h0);
        i_reset = 1'b0;
        step();

        // STORE then LOAD
        wb = wlog.size(); rb = rlog.size();
        issue(3'b010, 16'h0010, 32'h0000_0A00);
        check("store_busy", 32'(o_ready), 32'd0);
        wait_done(lat);
        check("store_lat", 32'(lat), 32'd2);
        step();
        check("store_nwr", 32'(wlog.size() - wb), 32'd1);
        check("store_wr", wlog[wb], 32'h0010_0A00);
        check("store_nrd", 32'(rlog.size() - rb), 32'd0);
        issue(3'b001, 16'h0010, 32'h0);
        wait_done(lat);
        check("load_lat", 32'(lat), 32'd2);
        check("load_data", o_read_data, 32'h0000_0A00);
        step();
        check("load_rdaddr", 32'(rlog[rb]), 32'h0010);
        check("load_sp", 32'(o_sp), 32'h0000_FFFF);

        // PUSH32 / POP32 round trip
        wb = wlog.size(); rb = rlog.size();
        issue(3'b101, 16'h0000, 32'h1234_5678);
        wait_done(lat);
        check("push32_lat", 32'(lat), 32'd3);
        check("push32_sp_stable", 32'(o_sp), 32'h0000_FFFF);
        step();
        check("push32_wr0", wlog[wb], 32'hFFFF_1234);
        check("push32_wr1", wlog[wb+1], 32'hFFFE_5678);
        check("push32_sp", 32'(o_sp), 32'h0000_FFFD);
        issue(3'b110, 16'h0000, 32'h0);
        wait_done(lat);
        check("pop32_lat", 32'(lat), 32'd3);
        check("pop32_data", o_read_data, 32'h1234_5678);
        step();
        check("pop32_rd0", 32'(rlog[rb]), 32'hFFFE);
        check("pop32_rd1", 32'(rlog[rb+1]), 32'hFFFF);
        check("pop32_sp", 32'(o_sp), 32'h0000_FFFF);

        // POP wrap FFFF->0000, PUSH wrap 0000->FFFF
        issue(3'b010, 16'h0000, 32'h0000_BEEF);
        wait_done(lat);
        step();
        rb = rlog.size();
        issue(3'b100, 16'h0000, 32'h0);
        wait_done(lat);
        check("pop_lat", 32'(lat), 32'd2);
        check("pop_data", o_read_data, 32'h0000_BEEF);
        step();
        check("pop_rdaddr", 32'(rlog[rb]), 32'h0000);
        check("pop_sp_wrap", 32'(o_sp), 32'h0000_0000);
        wb = wlog.size();
        issue(3'b011, 16'h0000, 32'hFFFF_0042);
        wait_done(lat);
        check("push_lat", 32'(lat), 32'd2);
        step();
        check("push_wr", wlog[wb], 32'h0000_0042);
        check("push_sp_wrap", 32'(o_sp), 32'h0000_FFFF);

        // LOAD held valid during PUSH32: ignored while busy, then taken once
        wb = wlog.size(); rb = rlog.size();
        i_req_valid  = 1'b1;
        i_op         = 3'b101;
        i_write_data = 32'hAAAA_5555;
        step();
        i_op         = 3'b001;
        i_address    = 16'h0010;
        i_write_data = 32'hFFFF_FFFF;
        wait_done(lat);
        check("hold_push32_lat", 32'(lat), 32'd3);
        step();
        check("hold_ready", 32'(o_ready), 32'd1);
        check("hold_wr0", wlog[wb], 32'hFFFF_AAAA);
        check("hold_wr1", wlog[wb+1], 32'hFFFE_5555);
        check("hold_no_early_rd", 32'(rlog.size() - rb), 32'd0);
        check("hold_sp", 32'(o_sp), 32'h0000_FFFD);
        db = done_cnt;
        step();
        i_req_valid = 1'b0;
        i_op        = 3'b000;
        wait_done(lat);
        check("hold_load_lat", 32'(lat), 32'd2);
        check("hold_load_data", o_read_data, 32'h0000_0A00);
        step(); step(); step(); step();
        check("hold_load_once", 32'(done_cnt - db), 32'd1);
        check("hold_load_nrd", 32'(rlog.size() - rb), 32'd1);
        check("hold_load_addr", 32'(rlog[rb]), 32'h0010);

        // Reset during WORD1 of PUSH32
        db = done_cnt;
        issue(3'b101, 16'h0000, 32'hDEAD_BEEF);
        step();
        check("abort_in_word1", 32'(o_mem_write), 32'd1);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_strobes", 32'({o_mem_read, o_mem_write}), 32'd0);
        check("abort_sp", 32'(o_sp), 32'h0000_FFFF);
        check("abort_ready", 32'(o_ready), 32'd1);
        step(); step(); step();
        check("abort_no_done", 32'(done_cnt - db), 32'd0);
        check("abort_sp_after", 32'(o_sp), 32'h0000_FFFF);

        // NOP and reserved op: accepted, no effect
        wb = wlog.size(); rb = rlog.size(); db = done_cnt;
        issue(3'b000, 16'h0010, 32'h1111_2222);
        check("nop_ready", 32'(o_ready), 32'd1);
        issue(3'b111, 16'h0010, 32'h3333_4444);
        check("rsvd_ready", 32'(o_ready), 32'd1);
        step(); step(); step();
        check("nop_rsvd_nwr", 32'(wlog.size() - wb), 32'd0);
        check("nop_rsvd_nrd", 32'(rlog.size() - rb), 32'd0);
        check("nop_rsvd_done", 32'(done_cnt - db), 32'd0);
        check("nop_rsvd_sp", 32'(o_sp), 32'h0000_FFFF);

        check("rd_wr_overlap", 32'(both_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
